// File: rtl/multdiv_controller.sv
// Sequences one multiply or divide at a time: latches operands, waits MULT_LATENCY edges or for div_done/timeout, then pulses data_resultRDY.
// No backpressure: a new start always wins, aborting any operation in flight without a result.
module multdiv_controller #(
    parameter int WIDTH        = 32,
    parameter int MULT_LATENCY = 2,
    parameter int DIV_TIMEOUT  = 40
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] mult_result,
    input  logic             mult_exception,
    output logic             div_start,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_result,
    input  logic             div_exception,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int CNT_MAX = (MULT_LATENCY > DIV_TIMEOUT) ? MULT_LATENCY : DIV_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MULT_LAST = CW'(MULT_LATENCY - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MULT_WAIT = 2'd1,
        DIV_RUN   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic              div_start_q, div_start_d;
    logic [WIDTH-1:0]  data_result_q, data_result_d;
    logic              data_exception_q, data_exception_d;
    logic              data_resultRDY_q, data_resultRDY_d;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        op_a_d           = op_a_q;
        op_b_d           = op_b_q;
        div_start_d      = 1'b0;
        data_result_d    = data_result_q;
        data_exception_d = data_exception_q;
        data_resultRDY_d = 1'b0;

        if (ctrl_MULT) begin
            op_a_d  = data_operandA;
            op_b_d  = data_operandB;
            cnt_d   = '0;
            state_d = MULT_WAIT;
        end else if (ctrl_DIV) begin
            if (data_operandB == '0) begin
                // Divide-by-zero is answered immediately; the divider never sees it.
                data_result_d    = '0;
                data_exception_d = 1'b1;
                data_resultRDY_d = 1'b1;
                cnt_d            = '0;
                state_d          = IDLE;
            end else begin
                op_a_d      = data_operandA;
                op_b_d      = data_operandB;
                div_start_d = 1'b1;
                cnt_d       = '0;
                state_d     = DIV_RUN;
            end
        end else begin
            case (state_q)
                MULT_WAIT: begin
                    if (cnt_q == MULT_LAST) begin
                        data_result_d    = mult_result;
                        data_exception_d = mult_exception;
                        data_resultRDY_d = 1'b1;
                        state_d          = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DIV_RUN: begin
                    if (div_done) begin
                        data_result_d    = div_result;
                        data_exception_d = div_exception;
                        data_resultRDY_d = 1'b1;
                        state_d          = IDLE;
                    end else if (cnt_q == DIV_LAST) begin
                        data_result_d    = '0;
                        data_exception_d = 1'b1;
                        data_resultRDY_d = 1'b1;
                        state_d          = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            op_a_q           <= '0;
            op_b_q           <= '0;
            div_start_q      <= 1'b0;
            data_result_q    <= '0;
            data_exception_q <= 1'b0;
            data_resultRDY_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            op_a_q           <= op_a_d;
            op_b_q           <= op_b_d;
            div_start_q      <= div_start_d;
            data_result_q    <= data_result_d;
            data_exception_q <= data_exception_d;
            data_resultRDY_q <= data_resultRDY_d;
        end
    end

    assign op_a           = op_a_q;
    assign op_b           = op_b_q;
    assign div_start      = div_start_q;
    assign data_result    = data_result_q;
    assign data_exception = data_exception_q;
    assign data_resultRDY = data_resultRDY_q;
    assign busy           = (state_q != IDLE);

endmodule
